// File: rtl/cpu_control.sv
// Fetch/decode/execute sequencer for the 8-bit CPU: owns PC, IR, operand byte and an
// 8x8 register file, issues memory and ALU requests, and consumes ALU results/flags.
`timescale 1ns/1ps
module cpu_control #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] mem_addr,
  output logic       mem_re,
  output logic       mem_we,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  output logic       alu_en,
  output logic [1:0] alu_op,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  input  logic [7:0] alu_out,
  input  logic       alu_zero,
  input  logic       alu_carry,
  output logic [7:0] pc,
  output logic       halted
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_OPFETCH, S_OPLATCH, S_MEM, S_LOADWB, S_EXEC, S_WB, S_HALT
  } state_t;

  localparam logic [1:0] CLS_MISC = 2'b00;
  localparam logic [1:0] CLS_SWAP = 2'b11;
  localparam logic [2:0] OP_STORE = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_STOP  = 3'b010;
  localparam logic [2:0] OP_JUMP  = 3'b011;
  localparam logic [2:0] OP_MSTR  = 3'b100;
  localparam logic [2:0] OP_INC   = 3'b101;
  localparam logic [2:0] OP_DEC   = 3'b110;

  state_t     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] op2_q, op2_d;
  logic [7:0] regs_q [0:7];
  logic [7:0] regs_d [0:7];

  logic [1:0] cls_s;
  logic [2:0] sub_s, r_s, wb_dst_s;
  logic       jump_take_s;

  assign cls_s    = ir_q[7:6];
  assign sub_s    = ir_q[5:3];
  assign r_s      = ir_q[2:0];
  assign wb_dst_s = (cls_s == CLS_MISC) ? r_s : sub_s;
  assign pc       = pc_q;

  // JUMP condition field: only 001/010 are conditional, every other code is unconditional
  always_comb begin
    case (r_s)
      3'b001:  jump_take_s = alu_zero;
      3'b010:  jump_take_s = alu_carry;
      default: jump_take_s = 1'b1;
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= 8'h00;
      op2_q   <= 8'h00;
      regs_q  <= '{default: 8'h00};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      op2_q   <= op2_d;
      regs_q  <= regs_d;
    end
  end

  // Next-state and architectural update logic
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    op2_d   = op2_q;
    regs_d  = regs_q;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        ir_d = mem_rdata;
        pc_d = pc_q + 8'd1;
        if (mem_rdata[7:6] == CLS_SWAP) begin
          regs_d[mem_rdata[5:3]] = regs_q[mem_rdata[2:0]];
          regs_d[mem_rdata[2:0]] = regs_q[mem_rdata[5:3]];
          state_d = S_FETCH;
        end else if (mem_rdata[7:6] != CLS_MISC) begin
          state_d = S_EXEC;
        end else begin
          case (mem_rdata[5:3])
            OP_STORE, OP_LOAD, OP_JUMP, OP_MSTR: state_d = S_OPFETCH;
            OP_STOP:                             state_d = S_HALT;
            OP_INC, OP_DEC:                      state_d = S_EXEC;
            default:                             state_d = S_FETCH;
          endcase
        end
      end
      S_OPFETCH: state_d = S_OPLATCH;
      S_OPLATCH: begin
        op2_d   = mem_rdata;
        pc_d    = pc_q + 8'd1;
        state_d = S_FETCH;
        case (sub_s)
          OP_STORE: regs_d[r_s] = mem_rdata;
          OP_JUMP: begin
            if (jump_take_s) begin
              pc_d = mem_rdata;
            end else begin
              pc_d = pc_q + 8'd1;
            end
          end
          OP_LOAD, OP_MSTR: state_d = S_MEM;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (sub_s == OP_LOAD) begin
          state_d = S_LOADWB;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_LOADWB: begin
        regs_d[r_s] = mem_rdata;
        state_d     = S_FETCH;
      end
      S_EXEC: state_d = S_WB;
      S_WB: begin
        regs_d[wb_dst_s] = alu_out;
        state_d          = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  // Strobes are decoded from state and forced low while reset is held
  always_comb begin
    mem_addr  = pc_q;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = 8'h00;
    alu_en    = 1'b0;
    alu_op    = 2'b00;
    alu_a     = 8'h00;
    alu_b     = 8'h00;
    halted    = 1'b0;
    case (state_q)
      S_FETCH, S_OPFETCH: mem_re = ~rst;
      S_MEM: begin
        mem_addr = op2_q;
        if (sub_s == OP_LOAD) begin
          mem_re = ~rst;
        end else begin
          mem_we    = ~rst;
          mem_wdata = regs_q[r_s];
        end
      end
      S_EXEC: begin
        alu_en = ~rst;
        if (cls_s == CLS_MISC) begin
          alu_op = 2'b00;
          alu_a  = ir_q;
          alu_b  = regs_q[r_s];
        end else begin
          alu_op = cls_s;
          alu_a  = regs_q[sub_s];
          alu_b  = regs_q[r_s];
        end
      end
      S_HALT:  halted = ~rst;
      default: mem_addr = pc_q;
    endcase
  end

endmodule

// File: tb/tb_cpu_control.sv
// Directed bench for cpu_control with memory and ALU models; memory writes are
// checked by a scoreboard monitor, timing and PC by directed checks.
`timescale 1ns/1ps
module tb_cpu_control;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] mem_addr, mem_wdata, alu_a, alu_b, pc;
  logic [7:0] mem_rdata = 8'h00;
  logic [7:0] alu_out = 8'h00;
  logic       mem_re, mem_we, alu_en, halted;
  logic       alu_zero = 1'b0;
  logic       alu_carry = 1'b0;
  logic [1:0] alu_op;

  always #5 clk = ~clk;

  cpu_control #(.RESET_PC(8'h00)) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .alu_en(alu_en), .alu_op(alu_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out), .alu_zero(alu_zero),
    .alu_carry(alu_carry), .pc(pc), .halted(halted)
  );

  logic [7:0] mem [0:255];
  logic       ld_en = 1'b0;
  logic [7:0] ld_addr = 8'h00, ld_data = 8'h00;
  logic [7:0] prog [$];
  logic [15:0] wq [$];
  int cyc = 0, alu_cnt = 0, overlap = 0;
  int checks = 0, errors = 0, mon_checks = 0, mon_errors = 0;

  // Synchronous single-port memory with a bench load port
  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  // Reference ALU: INC/DEC decoded from the instruction byte on operand a
  always @(posedge clk) begin
    logic [8:0] res;
    res = 9'h000;
    if (alu_en) begin
      case (alu_op)
        2'b01: res = {1'b0, alu_a} + {1'b0, alu_b};
        2'b10: res = {1'b0, alu_a} - {1'b0, alu_b};
        default: begin
          if (alu_a[5:3] == 3'b101) res = {1'b0, alu_b} + 9'd1;
          else res = {1'b0, alu_b} - 9'd1;
        end
      endcase
      alu_out   <= res[7:0];
      alu_zero  <= (res[7:0] == 8'h00);
      alu_carry <= res[8];
    end
  end

  always @(posedge clk) begin
    cyc     <= rst ? 0 : cyc + 1;
    alu_cnt <= rst ? 0 : (alu_en ? alu_cnt + 1 : alu_cnt);
  end

  // Scoreboard monitor: every write strobe must match the next expected write
  initial forever begin
    logic [15:0] exp;
    @(negedge clk);
    if (mem_re && mem_we) overlap++;
    if (mem_we) begin
      mon_checks++;
      if (wq.size() == 0) begin
        mon_errors++;
        $display("FAIL mem_write unexpected actual=%h:%h required=none", mem_addr, mem_wdata);
      end else begin
        exp = wq.pop_front();
        if ({mem_addr, mem_wdata} !== exp) begin
          mon_errors++;
          $display("FAIL mem_write actual=%h:%h required=%h:%h", mem_addr, mem_wdata, exp[15:8], exp[7:0]);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic load_prog(input logic [7:0] base);
    for (int i = 0; i < prog.size(); i++) begin
      ld_en = 1'b1; ld_addr = base + 8'(i); ld_data = prog[i];
      @(posedge clk); #1;
    end
    ld_en = 1'b0;
  endtask

  task automatic hold_reset();
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic wait_halt(output int hc);
    for (int i = 0; i < 300 && !halted; i++) @(negedge clk);
    hc = halted ? cyc : -1;
  endtask

  task automatic wait_cyc(input int n);
    for (int i = 0; i < 300 && cyc != n; i++) @(negedge clk);
    chk("cycle_reach", cyc, n);
  endtask

  initial begin
    int hc;
    @(posedge clk); #1;
    chk("rst_pc", pc, 8'h00);
    chk("rst_strobes", {mem_re, mem_we, alu_en, halted}, 4'b0000);

    // STORE r1,#5; STORE r2,#3; ADD r1,r2; STOP -> 4+4+4+2 cycles
    prog = '{8'h01, 8'h05, 8'h02, 8'h03, 8'h4A, 8'h10};
    load_prog(8'h00);
    rst = 1'b0;
    @(negedge clk);
    chk("first_fetch", {mem_re, mem_addr}, {1'b1, 8'h00});
    wait_halt(hc);
    chk("add_halt_cycles", hc, 14);
    chk("add_alu_en_cycles", alu_cnt, 1);
    chk("add_alu_result", alu_out, 8'h08);
    chk("add_halt_pc", pc, 8'h06);
    chk("halt_no_strobes", {mem_re, mem_we, alu_en}, 3'b000);

    // Same program, r1 dumped with M_STORE before STOP
    hold_reset();
    prog = '{8'h01, 8'h05, 8'h02, 8'h03, 8'h4A, 8'h21, 8'h90, 8'h10};
    load_prog(8'h00);
    wq.push_back({8'h90, 8'h08});
    rst = 1'b0;
    wait_halt(hc);
    chk("add_dump_cycles", hc, 19);
    chk("add_dump_drained", wq.size(), 0);

    // r3=FF; INC r3; JUMP zero,0x40 -> taken
    hold_reset();
    prog = '{8'h03, 8'hFF, 8'h2B, 8'h19, 8'h40}; load_prog(8'h00);
    prog = '{8'h23, 8'h92, 8'h10};               load_prog(8'h05);
    prog = '{8'h23, 8'h91, 8'h10};               load_prog(8'h40);
    wq.push_back({8'h91, 8'h00});
    rst = 1'b0;
    wait_halt(hc);
    chk("jz_taken_cycles", hc, 19);
    chk("jz_taken_pc", pc, 8'h43);
    chk("jz_taken_zero", alu_zero, 1'b1);
    chk("jz_taken_drained", wq.size(), 0);

    // r3=FE -> INC gives FF, jump falls through to 0x05
    hold_reset();
    prog = '{8'h03, 8'hFE}; load_prog(8'h00);
    wq.push_back({8'h92, 8'hFF});
    rst = 1'b0;
    wait_halt(hc);
    chk("jz_fall_pc", pc, 8'h08);
    chk("jz_fall_drained", wq.size(), 0);

    // STORE r1,#A5; M_STORE r1,0x80; LOAD r4,0x80; M_STORE r4,0x81; STOP
    hold_reset();
    prog = '{8'h01, 8'hA5, 8'h21, 8'h80, 8'h0C, 8'h80, 8'h24, 8'h81, 8'h10};
    load_prog(8'h00);
    wq.push_back({8'h80, 8'hA5});
    wq.push_back({8'h81, 8'hA5});
    rst = 1'b0;
    wait_halt(hc);
    chk("load_cycles", hc, 22);
    chk("load_drained", wq.size(), 0);

    // r1=11 r2=22 r5=5C; SWAP r1,r2; SWAP r5,r5; dump r1,r2,r5
    hold_reset();
    prog = '{8'h01, 8'h11, 8'h02, 8'h22, 8'h05, 8'h5C, 8'hCA, 8'hED,
             8'h21, 8'h83, 8'h22, 8'h84, 8'h25, 8'h85, 8'h10};
    load_prog(8'h00);
    wq.push_back({8'h83, 8'h22});
    wq.push_back({8'h84, 8'h11});
    wq.push_back({8'h85, 8'h5C});
    rst = 1'b0;
    wait_halt(hc);
    chk("swap_cycles", hc, 33);
    chk("swap_no_alu", alu_cnt, 0);
    chk("swap_drained", wq.size(), 0);

    // INC r3; JUMP always 0xFF; JUMP zero at 0xFF takes its operand from 0x00
    hold_reset();
    prog = '{8'h2B, 8'h18, 8'hFF}; load_prog(8'h00);
    prog = '{8'h19};               load_prog(8'hFF);
    rst = 1'b0;
    wait_cyc(8);
    chk("wrap_fetch_pc", pc, 8'hFF);
    wait_cyc(10);
    chk("wrap_opfetch", {mem_re, mem_addr}, {1'b1, 8'h00});
    wait_cyc(12);
    chk("wrap_fall_pc", pc, 8'h01);
    chk("wrap_fall_fetch", {mem_re, mem_addr}, {1'b1, 8'h01});

    // Reset during the MEM cycle of M_STORE suppresses the write
    hold_reset();
    prog = '{8'h3C};                             load_prog(8'h86);
    prog = '{8'h01, 8'hA5, 8'h21, 8'h86, 8'h10}; load_prog(8'h00);
    rst = 1'b0;
    wait_cyc(7);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_mem_no_we", {mem_we, mem_re}, 2'b00);
    @(posedge clk); #1;
    chk("rst_mem_pc", pc, 8'h00);
    chk("rst_mem_untouched", mem[8'h86], 8'h3C);
    prog = '{8'h21, 8'h87, 8'h10}; load_prog(8'h00);
    wq.push_back({8'h87, 8'h00});
    rst = 1'b0;
    wait_halt(hc);
    chk("rst_regs_cleared", wq.size(), 0);
    chk("halted_set", halted, 1'b1);

    // Reset while in HALT
    rst = 1'b1;
    #1;
    chk("halt_rst_drops", halted, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("halt_rst_refetch", {mem_re, mem_addr, halted}, {1'b1, 8'h00, 1'b0});
    hold_reset();

    chk("no_strobe_overlap", overlap, 0);
    checks += mon_checks;
    errors += mon_errors;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
